// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/branch/size encodings, EXE bundle.
// Pure definitions, no timing.
// No flow control of its own.
package rv32i_pkg;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [1:0] HB_WORD = 2'b00;
  localparam logic [1:0] HB_BYTE = 2'b01;
  localparam logic [1:0] HB_HALF = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd_ptr;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        ul;
    logic [1:0]  hb;
  } ex_bundle_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // funct3 -> ALU op for register and immediate arithmetic; alt selects SUB/SRA
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Load/store access size from funct3 (sign bit in f3[2] ignored)
  function automatic logic [1:0] hb_from_f3(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return HB_BYTE;
      2'd1:    return HB_HALF;
      default: return HB_WORD;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// Fetch, writeback and EXE-side signals of the decode stage.
// Pure wiring, no timing.
// Valid/ready on fetch and EXE sides; redirect and flush are unconditioned pulses.
interface decode_stage_hs_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic        wb_we;
  logic [4:0]  wb_rd_ptr;
  logic [31:0] wb_rd;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd_ptr;
  logic [3:0]  ex_alu_opcode;
  logic        ex_alu_src;
  logic        ex_reg_we;
  logic        ex_mem_we;
  logic        ex_mem_re;
  logic        ex_ul;
  logic [1:0]  ex_hb;
  logic        illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, stall, wb_we, wb_rd_ptr, wb_rd, ex_ready,
    output if_ready, redirect, redirect_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm,
           ex_rd_ptr, ex_alu_opcode, ex_alu_src, ex_reg_we, ex_mem_we, ex_mem_re,
           ex_ul, ex_hb, illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, stall, wb_we, wb_rd_ptr, wb_rd, ex_ready,
    input  if_ready, redirect, redirect_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm,
           ex_rd_ptr, ex_alu_opcode, ex_alu_src, ex_reg_we, ex_mem_we, ex_mem_re,
           ex_ul, ex_hb, illegal
  );
endinterface

// File: rtl/decode_stage_hs_regfile.sv
// 32x32 integer register file, x0 hardwired to zero.
// Reads combinational, writes take effect on the next clock edge.
// No flow control; write port always accepted.
module decode_stage_hs_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);
  logic [31:0] mem [32];

  // Register write; writes to x0 are discarded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : mem[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : mem[raddr_b];
endmodule

// File: rtl/decode_stage_hs.sv
// RV32I decode stage: regfile read, operand/control bundle, jump/branch resolution.
// Latency 1 from accept to ex_valid; redirect is registered, one cycle after accept.
// if_ready drops while EXE holds a bundle, on stall, and during a redirect pulse.
module decode_stage_hs
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          RF_BYPASS = 1'b1,
  parameter bit          HAS_JALR  = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  decode_stage_hs_if.slave bus
);
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  ex_bundle_t  dec;
  ex_bundle_t  ex_q;
  logic        dec_ill;
  logic        dec_take;
  logic [31:0] dec_target;

  logic        boot_done_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic        ex_valid_q;
  logic        illegal_q;
  logic        accept;

  assign instr   = bus.if_instr;
  assign pc      = bus.if_pc;
  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  // LUI has no rs1; its rs1 field is immediate bits
  assign rs1_idx = (opc == OP_LUI) ? 5'd0 : instr[19:15];
  assign rs2_idx = instr[24:20];

  decode_stage_hs_regfile u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we      (bus.wb_we),
    .waddr   (bus.wb_rd_ptr),
    .wdata   (bus.wb_rd),
    .raddr_a (rs1_idx),
    .rdata_a (rf_rd1),
    .raddr_b (rs2_idx),
    .rdata_b (rf_rd2)
  );

  // Forward a same-cycle writeback onto the operand reads
  always_comb begin
    rs1_val = rf_rd1;
    rs2_val = rf_rd2;
    if (RF_BYPASS && bus.wb_we) begin
      if (bus.wb_rd_ptr == rs1_idx && rs1_idx != 5'd0) rs1_val = bus.wb_rd;
      if (bus.wb_rd_ptr == rs2_idx && rs2_idx != 5'd0) rs2_val = bus.wb_rd;
    end
  end

  // Build the EXE bundle, flag illegal encodings and resolve control transfers
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.rs1     = rs1_val;
    dec.rs2     = rs2_val;
    dec.imm     = imm_i(instr);
    dec.rd_ptr  = instr[11:7];
    dec.alu_op  = ALU_ADD;
    dec_ill     = 1'b0;
    dec_take    = 1'b0;
    dec_target  = '0;
    case (opc)
      OP_ALU_REG: begin
        dec.reg_we = 1'b1;
        dec.alu_op = alu_from_f3(f3, f7[5]);
        if (f7 != 7'h00 && f7 != 7'h20) dec_ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) dec_ill = 1'b1;
      end
      OP_ALU_IMM: begin
        dec.reg_we  = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_op  = alu_from_f3(f3, (f3 == 3'd5) && instr[30]);
        if (f3 == 3'd1 || f3 == 3'd5) dec.imm = {27'd0, instr[24:20]};
      end
      OP_LOAD: begin
        dec.reg_we  = 1'b1;
        dec.alu_src = 1'b1;
        dec.mem_re  = 1'b1;
        dec.hb      = hb_from_f3(f3);
        dec.ul      = f3[2];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec_ill = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src = 1'b1;
        dec.mem_we  = 1'b1;
        dec.imm     = imm_s(instr);
        dec.hb      = hb_from_f3(f3);
        if (f3 > 3'd2) dec_ill = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm    = imm_b(instr);
        dec.alu_op = (f3[2:1] == 2'b00) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        dec_take   = branch_taken(f3, rs1_val, rs2_val);
        dec_target = pc + imm_b(instr);
      end
      OP_JAL: begin
        dec.rs1     = pc;
        dec.imm     = 32'd4;
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
        dec_take    = 1'b1;
        dec_target  = pc + imm_j(instr);
      end
      OP_JALR: begin
        if (HAS_JALR) begin
          dec.rs1     = pc;
          dec.imm     = 32'd4;
          dec.alu_src = 1'b1;
          dec.reg_we  = 1'b1;
          dec_take    = 1'b1;
          dec_target  = (rs1_val + imm_i(instr)) & ~32'd1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LUI: begin
        dec.rs1     = '0;
        dec.imm     = imm_u(instr);
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      OP_AUIPC: begin
        dec.rs1     = pc;
        dec.imm     = imm_u(instr);
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal encodings travel on as a side-effect-free NOP
    if (dec_ill) begin
      dec        = '0;
      dec.pc     = pc;
      dec_take   = 1'b0;
    end
  end

  // Nothing is taken before the reset redirect has gone out to fetch
  assign bus.if_ready = (~ex_valid_q | bus.ex_ready) & ~bus.stall & ~redirect_q & boot_done_q;
  assign accept       = bus.if_valid & bus.if_ready & ~bus.flush;

  // Output register, redirect pulse and illegal pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_done_q   <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= RESET_PC;
      ex_valid_q    <= 1'b0;
      ex_q          <= '0;
      illegal_q     <= 1'b0;
    end else begin
      boot_done_q <= 1'b1;
      redirect_q  <= 1'b0;
      illegal_q   <= 1'b0;
      if (!boot_done_q) begin
        redirect_q    <= 1'b1;
        redirect_pc_q <= RESET_PC;
      end
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (accept) begin
        ex_valid_q <= 1'b1;
        ex_q       <= dec;
        illegal_q  <= dec_ill;
        if (dec_take) begin
          redirect_q    <= 1'b1;
          redirect_pc_q <= dec_target;
        end
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.redirect      = redirect_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.illegal       = illegal_q;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rd_ptr     = ex_q.rd_ptr;
  assign bus.ex_alu_opcode = ex_q.alu_op;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_we     = ex_q.reg_we;
  assign bus.ex_mem_we     = ex_q.mem_we;
  assign bus.ex_mem_re     = ex_q.mem_re;
  assign bus.ex_ul         = ex_q.ul;
  assign bus.ex_hb         = ex_q.hb;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Randomized and directed bench for decode_stage_hs against an ISA-level model.
// One model step per clock; outputs sampled on the falling edge.
// Drives random ex_ready/stall/flush to exercise hold, drain and redirect blocking.
module tb_decode_stage_hs;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  decode_stage_hs_if bus ();
  decode_stage_hs_if bus_nj ();

  decode_stage_hs #(.RESET_PC(RESET_PC), .RF_BYPASS(1'b1), .HAS_JALR(1'b1)) dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (bus.slave));
  decode_stage_hs #(.RESET_PC(RESET_PC), .RF_BYPASS(1'b1), .HAS_JALR(1'b0)) dut_nj (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (bus_nj.slave));

  assign bus_nj.if_valid  = bus.if_valid;
  assign bus_nj.if_instr  = bus.if_instr;
  assign bus_nj.if_pc     = bus.if_pc;
  assign bus_nj.flush     = bus.flush;
  assign bus_nj.stall     = bus.stall;
  assign bus_nj.wb_we     = bus.wb_we;
  assign bus_nj.wb_rd_ptr = bus.wb_rd_ptr;
  assign bus_nj.wb_rd     = bus.wb_rd;
  assign bus_nj.ex_ready  = bus.ex_ready;

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm, tgt;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src, we, mwe, mre, ul;
    logic [1:0]  hb;
    logic        ill, take, chk_rs2, chk_imm, chk_alu;
  } exp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_rf [32];
  logic        m_exv, m_redir, m_ill;
  logic [31:0] m_rpc;
  exp_t        m_b;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic logic [1:0] size_code(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 2'b01;
    if (f3 == 3'd1 || f3 == 3'd5) return 2'b10;
    return 2'b00;
  endfunction

  // ISA-level expectation for one accepted instruction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii, is_, ib, iu, ij;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = $signed(ins) >>> 20;
    is_ = {ii[31:5], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = ins & 32'hFFFF_F000;
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '0;
    e.pc = pc; e.rs1 = a; e.rs2 = b; e.rd = ins[11:7];
    e.chk_rs2 = 1'b1; e.chk_imm = 1'b1; e.chk_alu = 1'b1;
    case (ins[6:0])
      7'h33: begin
        e.we = 1'b1; e.chk_imm = 1'b0; e.alu = alu_code(f3, ins[30]);
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        e.we = 1'b1; e.src = 1'b1; e.alu = alu_code(f3, f3 == 3'd5 && ins[30]);
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : ii;
      end
      7'h03: begin
        e.we = 1'b1; e.src = 1'b1; e.mre = 1'b1; e.imm = ii; e.hb = size_code(f3);
        e.ul = (f3 == 3'd4 || f3 == 3'd5); e.ill = (f3 == 3'd3 || f3 >= 3'd6);
      end
      7'h23: begin
        e.mwe = 1'b1; e.src = 1'b1; e.imm = is_; e.hb = size_code(f3); e.ill = f3 > 3'd2;
      end
      7'h63: begin
        e.chk_alu = 1'b0; e.imm = ib; e.tgt = pc + ib;
        case (f3)
          3'd0: e.take = (a == b);
          3'd1: e.take = (a != b);
          3'd4: e.take = ($signed(a) < $signed(b));
          3'd5: e.take = !($signed(a) < $signed(b));
          3'd6: e.take = (a < b);
          3'd7: e.take = !(a < b);
          default: e.take = 1'b0;
        endcase
      end
      7'h6F, 7'h67: begin
        e.rs1 = pc; e.imm = 32'd4; e.src = 1'b1; e.we = 1'b1; e.take = 1'b1;
        e.chk_rs2 = 1'b0;
        e.tgt = (ins[3]) ? pc + ij : ((a + ii) & 32'hFFFF_FFFE);
      end
      7'h37: begin e.rs1 = 32'd0; e.imm = iu; e.src = 1'b1; e.we = 1'b1; e.chk_rs2 = 1'b0; end
      7'h17: begin e.rs1 = pc; e.imm = iu; e.src = 1'b1; e.we = 1'b1; e.chk_rs2 = 1'b0; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.we = 1'b0; e.mwe = 1'b0; e.mre = 1'b0; e.take = 1'b0; end
    return e;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_rd_ptr == idx) return bus.wb_rd;
    return m_rf[idx];
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic stl, input logic fl,
                       input logic we, input logic [4:0] wp, input logic [31:0] wd);
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc; bus.ex_ready = rdy;
    bus.stall = stl; bus.flush = fl; bus.wb_we = we; bus.wb_rd_ptr = wp; bus.wb_rd = wd;
  endtask

  task automatic model_reset();
    m_exv = 1'b0; m_redir = 1'b0; m_ill = 1'b0; m_rpc = RESET_PC; m_b = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // One clock: check ready, advance model on the edge, check outputs on the falling edge
  task automatic step();
    logic [31:0] ins;
    logic [4:0]  i1;
    logic        rdy, acc;
    exp_t        e;
    #1;
    ins = bus.if_instr;
    rdy = (!m_exv || bus.ex_ready) && !bus.stall && !m_redir;
    expect_eq("if_ready", bus.if_ready, rdy);
    acc = bus.if_valid && rdy && !bus.flush;
    i1 = (ins[6:0] == 7'h37) ? 5'd0 : ins[19:15];
    e = model(ins, bus.if_pc, rf_read(i1), rf_read(ins[24:20]));
    @(posedge clk_i);
    if (bus.wb_we && bus.wb_rd_ptr != 5'd0) m_rf[bus.wb_rd_ptr] = bus.wb_rd;
    m_ill = 1'b0;
    m_redir = acc && e.take;
    if (m_redir) m_rpc = e.tgt;
    if (bus.flush) m_exv = 1'b0;
    else if (acc) begin m_exv = 1'b1; m_b = e; m_ill = e.ill; end
    else if (bus.ex_ready) m_exv = 1'b0;
    @(negedge clk_i);
    expect_eq("ex_valid", bus.ex_valid, m_exv);
    expect_eq("redirect", bus.redirect, m_redir);
    expect_eq("redirect_pc", bus.redirect_pc, m_rpc);
    expect_eq("illegal", bus.illegal, m_ill);
    if (m_exv) begin
      expect_eq("ex_pc", bus.ex_pc, m_b.pc);
      expect_eq("ex_reg_we", bus.ex_reg_we, m_b.we);
      expect_eq("ex_mem_we", bus.ex_mem_we, m_b.mwe);
      expect_eq("ex_mem_re", bus.ex_mem_re, m_b.mre);
      if (!m_b.ill) begin
        expect_eq("ex_rs1", bus.ex_rs1, m_b.rs1);
        expect_eq("ex_alu_src", bus.ex_alu_src, m_b.src);
        expect_eq("ex_ul", bus.ex_ul, m_b.ul);
        expect_eq("ex_hb", bus.ex_hb, m_b.hb);
        if (m_b.chk_rs2) expect_eq("ex_rs2", bus.ex_rs2, m_b.rs2);
        if (m_b.chk_imm) expect_eq("ex_imm", bus.ex_imm, m_b.imm);
        if (m_b.chk_alu) expect_eq("ex_alu", bus.ex_alu_opcode, m_b.alu);
        if (m_b.we) expect_eq("ex_rd", bus.ex_rd_ptr, m_b.rd);
      end
    end
  endtask

  // Check reset state, release, and check the single-cycle reset redirect
  task automatic release_and_boot();
    drive(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
    @(negedge clk_i);
    expect_eq("rst_ex_valid", bus.ex_valid, 0);
    expect_eq("rst_redirect", bus.redirect, 0);
    expect_eq("rst_redirect_pc", bus.redirect_pc, RESET_PC);
    expect_eq("rst_illegal", bus.illegal, 0);
    expect_eq("rst_ex_reg_we", bus.ex_reg_we, 0);
    expect_eq("rst_ex_pc", bus.ex_pc, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    expect_eq("boot_redirect", bus.redirect, 1);
    expect_eq("boot_redirect_pc", bus.redirect_pc, RESET_PC);
    expect_eq("boot_if_ready", bus.if_ready, 0);
    m_redir = 1'b1;
    m_rpc = RESET_PC;
  endtask

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    logic [2:0] btab [6];
    int k;
    btab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    f3 = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    k = $urandom_range(0, 9);
    f7 = (k < 5) ? 7'h00 : ((k < 9) ? 7'h20 : 7'($urandom));
    case ($urandom_range(0, 9))
      0: return {f7, rr(), rr(), f3, rr(), 7'h33};
      1: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {imm, rr(), f3, rr(), 7'h13};
      end
      2: return {imm, rr(), f3, rr(), 7'h03};
      3: return {imm[11:5], rr(), rr(), 3'($urandom_range(0, 3)), imm[4:0], 7'h23};
      4: return {imm[11:5], rr(), rr(), btab[$urandom_range(0, 5)], imm[4:0], 7'h63};
      5: return {20'($urandom), rr(), 7'h6F};
      6: return {imm, rr(), 3'd0, rr(), 7'h67};
      7: return {20'($urandom), rr(), 7'h37};
      8: return {20'($urandom), rr(), 7'h17};
      default: return {25'($urandom), ($urandom_range(0, 1) != 0) ? 7'h0F : 7'h73};
    endcase
  endfunction

  initial begin
    drive(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
    model_reset();
    #22;
    release_and_boot();

    // Reset redirect cycle blocks a waiting bundle; ADDI x1,x0,5 then accepted
    drive(1, 32'h0050_0093, 32'h0, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    step();
    expect_eq("addi_valid", bus.ex_valid, 1);
    expect_eq("addi_rs1", bus.ex_rs1, 0);
    expect_eq("addi_imm", bus.ex_imm, 5);
    expect_eq("addi_alu_src", bus.ex_alu_src, 1);
    expect_eq("addi_reg_we", bus.ex_reg_we, 1);
    expect_eq("addi_alu", bus.ex_alu_opcode, 0);

    // Backpressure: bundle held for 3 cycles, then next accepted as ready rises
    drive(1, 32'h0070_0113, 32'h4, 0, 0, 0, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_eq("hold_pc", bus.ex_pc, 32'h0);
    end
    bus.ex_ready = 1'b1;
    step();
    expect_eq("release_pc", bus.ex_pc, 32'h4);

    // BEQ x0,x0,+16 at 0x40 redirects to 0x50; wrong-path bundle refused
    drive(1, 32'h0000_0863, 32'h40, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    expect_eq("beq_redirect", bus.redirect, 1);
    expect_eq("beq_target", bus.redirect_pc, 32'h50);
    drive(1, 32'h0070_0113, 32'h44, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    expect_eq("wrong_path_dropped", bus.ex_valid, 0);
    drive(1, 32'h0000_1863, 32'h50, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    expect_eq("bne_no_redirect", bus.redirect, 0);

    // JALR x1,8(x2) with x2=0x103
    drive(0, 32'd0, 32'd0, 1, 0, 0, 1, 5'd2, 32'h103);
    step();
    drive(1, 32'h0081_00E7, 32'h60, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    expect_eq("jalr_target", bus.redirect_pc, 32'h10A);
    expect_eq("jalr_rs1", bus.ex_rs1, 32'h60);
    expect_eq("jalr_imm", bus.ex_imm, 4);
    expect_eq("nojalr_illegal", bus_nj.illegal, 1);
    expect_eq("nojalr_valid", bus_nj.ex_valid, 1);
    expect_eq("nojalr_reg_we", bus_nj.ex_reg_we, 0);
    expect_eq("nojalr_redirect", bus_nj.redirect, 0);
    drive(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
    step();

    // Bypass: x5 written in the same cycle ADD x6,x5,x0 is read; x0 stays 0
    drive(1, 32'h0002_8333, 32'h70, 1, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    step();
    expect_eq("bypass_rs1", bus.ex_rs1, 32'hDEAD_BEEF);
    drive(1, 32'h0000_03B3, 32'h74, 1, 0, 0, 1, 5'd0, 32'h1234_5678);
    step();
    expect_eq("x0_rs1", bus.ex_rs1, 0);

    // Flush beats an accepted JAL
    drive(1, 32'h0080_00EF, 32'h200, 1, 0, 1, 0, 5'd0, 32'd0);
    step();
    expect_eq("flush_valid", bus.ex_valid, 0);
    expect_eq("flush_no_redirect", bus.redirect, 0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 4, rr(), $urandom);
      step();
    end

    // Asynchronous reset while stalled with a held bundle
    drive(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    drive(1, 32'h0050_0093, 32'h300, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    drive(1, 32'h0070_0113, 32'h304, 0, 1, 0, 0, 5'd0, 32'd0);
    step();
    expect_eq("stall_held", bus.ex_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    expect_eq("async_rst_valid", bus.ex_valid, 0);
    expect_eq("async_rst_redirect", bus.redirect, 0);
    model_reset();
    release_and_boot();
    drive(1, 32'h0050_0093, 32'h0, 1, 0, 0, 0, 5'd0, 32'd0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
RV32I decode stage with valid/ready handshakes on both sides, replacing the fixed fetch/execute two-state sequencer. Sits between fetch and execute. Contains the register file (with optional write-through bypass), produces the EXE operand/control bundle, and resolves JAL, JALR and all B-type branches. Resolution issues a registered redirect to fetch and kills one wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, redirect target driven for one cycle after reset release
RF_BYPASS, 1, 1 = a WB write to rs1/rs2 in the same cycle is forwarded to the read
HAS_JALR, 1, 1 = opcode 1100111 decoded as JALR; 0 = treated as illegal

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
if_valid_i  in  1  fetch bundle valid
if_ready_o  out  1  decode accepts bundle
if_instr_i  in  32  instruction word
if_pc_i  in  32  PC of instruction
redirect_o  out  1  one-cycle pulse: fetch must restart at redirect_pc_o
redirect_pc_o  out  32  redirect target
flush_i  in  1  kill the instruction held in the output register (from a later stage)
stall_i  in  1  external hazard stall; forces if_ready_o low
wb_we_i  in  1  register write enable
wb_rd_ptr_i  in  5  write index
wb_rd_i  in  32  write data
ex_valid_o  out  1  EXE bundle valid
ex_ready_i  in  1  EXE accepts bundle
ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o  out  32 each  operands
ex_rd_ptr_o  out  5  destination
ex_alu_opcode_o  out  4  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
ex_alu_src_o, ex_reg_we_o, ex_mem_we_o, ex_mem_re_o, ex_ul_o  out  1 each  controls
ex_hb_o  out  2  00 word, 01 byte, 10 half
illegal_o  out  1  one-cycle pulse on accepting an unknown opcode or illegal funct

Behaviour:
- Reset values:
  - All ex_* outputs 0; ex_valid_o=0; illegal_o=0.
  - redirect_o=0 and redirect_pc_o=RESET_PC while reset is asserted.
- First cycle after reset release: redirect_o=1 with redirect_pc_o=RESET_PC; no instruction is accepted in that cycle.
- Ready rule: if_ready_o = (~ex_valid_o | ex_ready_i) & ~stall_i & ~redirect_o.
- Accept = if_valid_i & if_ready_o.
- Output register: on accept, load the bundle and set ex_valid_o=1 on the next edge (latency 1).
- Drain: on ex_ready_i with no accept, clear ex_valid_o.
- Hold: while ex_valid_o & ~ex_ready_i, the bundle is held stable.
- flush_i: clears ex_valid_o on the next edge and blocks the same-cycle accept; it takes priority over everything except reset.
- Register file:
  - x0 reads 0.
  - Reads are combinational on instr[19:15] and instr[24:20]; the rs1 index is forced to 0 for LUI.
  - With RF_BYPASS=1, when wb_we_i is set and wb_rd_ptr_i matches a nonzero read index, the read returns wb_rd_i.
- Operand selection:
  - R/I/S/B types: rs1, rs2, sign-extended immediate.
  - I-type shifts: imm = zero-extended shamt.
  - LUI: rs1=0, imm=U. AUIPC: rs1=pc, imm=U.
  - JAL/JALR: rs1=pc, imm=4, alu_src=1, ADD, so rd = pc+4.
- Control: same encoding as the existing decoder.
  - Loads: mem_re=1, hb from funct3 (0,4→01; 1,5→10; 2→00); ul=1 for funct3 4 and 5.
  - Stores: mem_we=1, hb from funct3.
  - B-type: reg_we=0.
- Branch resolution on accept (32-bit adds, wrap-around):
  - JAL: target = pc + IMM_J.
  - JALR: target = (rs1 + IMM_I) & ~1.
  - Taken B-type: target = pc + IMM_B.
  - Registered: redirect_o=1 and redirect_pc_o=target on the next edge, lasting one cycle.
  - While redirect_o=1, if_ready_o=0, so the wrong-path bundle in flight is not accepted. Fetch drops its own stale bundle on seeing redirect_o.
  - Not-taken branches: no redirect.
- Illegal instruction: any of
  - unknown opcode;
  - R-type funct7 not in {00, 20}, or 20 on a funct other than ADD/SRA;
  - store funct3 > 2;
  - load funct3 ∈ {3, 6, 7}.
  On accept: illegal_o pulses, the bundle is injected as a NOP (all write enables 0), and no redirect is issued.
- Simultaneous events:
  - flush_i together with an accepted branch: flush wins; no redirect is issued.
  - A WB write in the same cycle as a read uses the bypass rule.
- Reset mid-operation: clears ex_valid_o and any pending redirect immediately (asynchronously), then issues the RESET_PC redirect after release.

Decomposition:
- Shared package rv32i_pkg:
  - opcode localparams (ALU_REG, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - ALU opcode encodings;
  - branch funct3 codes;
  - hb encodings;
  - immediate-extraction functions imm_i/s/b/u/j.
- One sub-module: the existing regfile, instantiated unchanged. Bypass muxing lives in decode_stage_hs.

Test Plan:
- Reset release → redirect_o=1, redirect_pc_o=RESET_PC for exactly one cycle, if_ready_o=0 that cycle → then ADDI x1,x0,5 (00500093) at pc 0 → next cycle ex_valid_o=1, rs1=0, imm=5, alu_src=1, reg_we=1, opcode ADD.
- Backpressure: hold ex_ready_i=0 for 3 cycles with if_valid_i=1 → if_ready_o=0, bundle stable; raise ex_ready_i → next instruction accepted in the same cycle.
- BEQ x0,x0,+16 at pc 0x40 → redirect_o pulses with 0x50; the next if_valid bundle is not accepted during the pulse; BNE x0,x0 → no redirect.
- JALR x1,8(x2) with x2=0x103 → redirect_pc_o=0x10A; bundle rs1=pc, imm=4; with HAS_JALR=0 → illegal_o pulse, NOP bundle.
- Bypass: wb_we_i=1, x5←0xDEAD_BEEF in the same cycle ADD x6,x5,x0 is accepted → ex_rs1_o=0xDEADBEEF; write to x0 → reads 0.
- flush_i asserted in the same cycle as an accepted JAL → ex_valid_o=0 next cycle, no redirect; async reset asserted mid-stall → ex_valid_o=0 immediately.
